// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU and data memory.
// Misses are served by 4-byte block write-back/refill transfers handshaked on MEM_BUSYWAIT.
module data_cache_controller #(
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [7:0]        WRITEDATA,
  output logic [7:0]        READDATA,
  output logic              BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-3:0] MEM_ADDRESS,
  output logic [31:0]       MEM_WRITEDATA,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t             state_q, state_d;
  logic               first_q, first_d;
  logic [NBLK-1:0]    valid_q, valid_d;
  logic [NBLK-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q [NBLK];
  logic [TAG_W-1:0]   tag_d [NBLK];
  logic [31:0]        data_q [NBLK];
  logic [31:0]        data_d [NBLK];
  logic [7:0]         readdata_q, readdata_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-3:0]  mem_address_q, mem_address_d;
  logic [31:0]        mem_writedata_q, mem_writedata_d;

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [4:0]         byte_lsb;
  logic               hit;
  logic               req;
  logic               read_hit;
  logic [7:0]         sel_byte;

  assign addr_tag   = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_index = ADDRESS[2 +: INDEX_W];
  assign byte_lsb   = {ADDRESS[1:0], 3'b000};
  assign hit        = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign req        = READ | WRITE;
  assign sel_byte   = data_q[addr_index][byte_lsb +: 8];
  // READ together with WRITE behaves as a store, so it never drives load data.
  assign read_hit   = (state_q == IDLE) && READ && !WRITE && hit;

  // Gated by RESET so a request held through reset does not stall the CPU.
  assign BUSYWAIT      = RESET && req && ((state_q != IDLE) || !hit);
  assign READDATA      = read_hit ? sel_byte : readdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;

  always_comb begin
    state_d         = state_q;
    first_d         = 1'b0;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    tag_d           = tag_q;
    data_d          = data_q;
    readdata_d      = readdata_q;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = '0;
    mem_writedata_d = '0;

    case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (WRITE) begin
            data_d[addr_index][byte_lsb +: 8] = WRITEDATA;
            dirty_d[addr_index]               = 1'b1;
          end else begin
            readdata_d = sel_byte;
          end
        end else if (req) begin
          state_d = dirty_q[addr_index] ? WRITEBACK : FETCH;
          first_d = 1'b1;
        end
      end
      // The memory only raises MEM_BUSYWAIT a cycle after the request, so the
      // first cycle of each transfer must not be taken as completion.
      WRITEBACK: begin
        if (!first_q && !MEM_BUSYWAIT) begin
          state_d = FETCH;
          first_d = 1'b1;
        end
      end
      FETCH: begin
        if (!first_q && !MEM_BUSYWAIT) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        data_d[addr_index]  = MEM_READDATA;
        tag_d[addr_index]   = addr_tag;
        valid_d[addr_index] = 1'b1;
        dirty_d[addr_index] = 1'b0;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      WRITEBACK: begin
        mem_write_d     = 1'b1;
        mem_address_d   = {tag_q[addr_index], addr_index};
        mem_writedata_d = data_q[addr_index];
      end
      FETCH: begin
        mem_read_d    = 1'b1;
        mem_address_d = ADDRESS[ADDR_W-1:2];
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q         <= IDLE;
      first_q         <= 1'b0;
      valid_q         <= '0;
      dirty_q         <= '0;
      for (int i = 0; i < NBLK; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      readdata_q      <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      first_q         <= first_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      tag_q           <= tag_d;
      data_q          <= data_d;
      readdata_q      <= readdata_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

endmodule
